// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// The GAP state is only reachable when SEQ_PATTERN_TX_GAP_EN is defined.
package seq_pattern_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap,
    StDone
  } state_e;

  function automatic int unsigned calc_len_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // A zero or oversize length selects the full register width.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

  function automatic int unsigned eff_reps(input int unsigned reps);
    return (reps == 0) ? 1 : reps;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_shreg.sv
// Load/shift-left register. A load stores din already advanced by one bit, because the
// first bit (din[sel]) goes out on the same edge; shift_bit is the next bit to send.
module seq_pattern_tx_shreg #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [SEL_W-1:0] sel,
  output logic             load_bit,
  output logic             shift_bit
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din << 1;
    end else if (shift) begin
      data_q <= data_q << 1;
    end
  end

  assign load_bit  = din[sel];
  assign shift_bit = data_q[sel];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends len bits MSB-first, reps times, then pulses done.
// Defining SEQ_PATTERN_TX_GAP_EN inserts one idle cycle between consecutive frames.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  localparam int unsigned LEN_W = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SEL_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] frame_cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] len_eff;
  logic [REP_W-1:0] reps_eff;
  logic [LEN_W-1:0] sel_len;
  logic             last_bit;
  logic             last_frame;
  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_din;
  logic [SEL_W-1:0] sr_sel;
  logic             load_bit;
  logic             shift_bit;

  always_comb begin
    len_eff    = LEN_W'(eff_len(32'(len), WIDTH));
    reps_eff   = REP_W'(eff_reps(32'(reps)));
    last_bit   = (bit_cnt_q == len_q - 1'b1);
    last_frame = (frame_cnt_q == reps_q - 1'b1);
    // In IDLE the register and tap come straight from the inputs being accepted.
    sr_din     = (state_q == StIdle) ? pattern : pat_q;
    sel_len    = (state_q == StIdle) ? len_eff : len_q;
    sr_sel     = SEL_W'(sel_len - 1'b1);
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    case (state_q)
      StIdle: sr_load = start;
      StShift: begin
        if (!last_bit) begin
          sr_shift = 1'b1;
        end else if (!last_frame) begin
`ifdef SEQ_PATTERN_TX_GAP_EN
          sr_load = 1'b0;
`else
          sr_load = 1'b1;
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_GAP_EN
      StGap: sr_load = 1'b1;
`endif
      default: ;
    endcase
  end

  seq_pattern_tx_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift    (sr_shift),
    .din      (sr_din),
    .sel      (sr_sel),
    .load_bit (load_bit),
    .shift_bit(shift_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      reps_q      <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StShift;
            pat_q       <= pattern;
            len_q       <= len_eff;
            reps_q      <= reps_eff;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            ser_out_q   <= load_bit;
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StShift: begin
          if (!last_bit) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            ser_out_q <= shift_bit;
          end else if (!last_frame) begin
            bit_cnt_q   <= '0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
`ifdef SEQ_PATTERN_TX_GAP_EN
            state_q     <= StGap;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
`else
            ser_out_q   <= load_bit;
`endif
          end else begin
            state_q     <= StDone;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`ifdef SEQ_PATTERN_TX_GAP_EN
        StGap: begin
          state_q     <= StShift;
          ser_out_q   <= load_bit;
          ser_valid_q <= 1'b1;
        end
`endif
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: vector table driving a bit scoreboard, plus
// hand-written reset, mid-frame reset and held-start sequences.
module tb_seq_pattern_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned REP_W = 4;
  localparam int unsigned LEN_W = $clog2(WIDTH) + 1;
`ifdef SEQ_PATTERN_TX_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    bit               poke;
    int               exp_nbits;
    int               exp_frames;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass = 0;
  bit exp_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .WIDTH(WIDTH),
    .REP_W(REP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .len      (len),
    .reps     (reps),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ser_out"}, int'(ser_out), 0);
    check({tag, " ser_valid"}, int'(ser_valid), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
  endtask

  task automatic run_xfer(input vec_t v);
    int lb, rf, nbits, nbusy, ngap, cyc, exp_busy;
    bit seen_done, b;
    lb = (v.len == 0 || int'(v.len) > WIDTH) ? WIDTH : int'(v.len);
    rf = (v.reps == 0) ? 1 : int'(v.reps);
    for (int f = 0; f < rf; f++)
      for (int i = lb - 1; i >= 0; i--) exp_q.push_back(v.pattern[i]);
    nbits = 0; nbusy = 0; ngap = 0; cyc = 0; seen_done = 1'b0;
    exp_busy = v.exp_nbits + (GapEn ? v.exp_frames - 1 : 0);

    @(negedge clk);
    start = 1'b1; pattern = v.pattern; len = v.len; reps = v.reps;
    @(posedge clk);
    #1;
    // Inputs change after acceptance; the transfer must not notice.
    start = 1'b0; pattern = ~v.pattern; len = LEN_W'(1); reps = '0;
    while (!seen_done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({v.name, " first-bit latency"}, int'(ser_valid), 1);
      if (done) begin
        seen_done = 1'b1;
        check({v.name, " busy in done cycle"}, int'(busy), 0);
        check({v.name, " valid in done cycle"}, int'(ser_valid), 0);
      end else begin
        if (busy) nbusy++;
        if (busy && !ser_valid) ngap++;
        if (ser_valid) begin
          nbits++;
          if (exp_q.size() == 0) begin
            check({v.name, " extra bit count"}, nbits, v.exp_nbits);
          end else begin
            b = exp_q.pop_front();
            check($sformatf("%s bit %0d", v.name, nbits), int'(ser_out), int'(b));
          end
        end else begin
          check({v.name, " ser_out low when not valid"}, int'(ser_out), 0);
        end
        if (v.poke) begin
          start = 1'($urandom_range(0, 1));
          pattern = WIDTH'($urandom);
          len = LEN_W'($urandom);
          reps = REP_W'($urandom);
        end
      end
    end
    start = 1'b0;
    check({v.name, " done seen"}, int'(seen_done), 1);
    check({v.name, " bit count"}, nbits, v.exp_nbits);
    check({v.name, " busy cycles"}, nbusy, exp_busy);
    check({v.name, " gap cycles"}, ngap, GapEn ? v.exp_frames - 1 : 0);
    check({v.name, " scoreboard drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check({v.name, " done one cycle"}, int'(done), 0);
    check({v.name, " idle after done"}, int'(busy), 0);
  endtask

  initial begin
    int nv, nd, cyc, r0, r1;
    logic prev_v;

    vecs[0] = '{"basic",   8'b0000_0001, LEN_W'(3), REP_W'(1),  1'b0, 3,  1};
    vecs[1] = '{"rep_a5",  8'hA5,        LEN_W'(0), REP_W'(2),  1'b0, 16, 2};
    vecs[2] = '{"len9",    8'hA5,        LEN_W'(9), REP_W'(1),  1'b0, 8,  1};
    vecs[3] = '{"reps0",   8'h3C,        LEN_W'(5), REP_W'(0),  1'b0, 5,  1};
    vecs[4] = '{"reps15",  8'h96,        LEN_W'(2), REP_W'(15), 1'b0, 30, 15};
    vecs[5] = '{"poke",    8'hC3,        LEN_W'(8), REP_W'(3),  1'b1, 24, 3};
    vecs[6] = '{"len1",    8'h5A,        LEN_W'(1), REP_W'(2),  1'b0, 2,  2};

    // Reset with start asserted: nothing may start.
    rst = 1'b1; start = 1'b1; pattern = 8'hFF; len = '0; reps = REP_W'(1);
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset");
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("post-reset idle");

    foreach (vecs[i]) run_xfer(vecs[i]);

    // Reset in the middle of a frame: outputs clear at once, no done.
    @(negedge clk);
    start = 1'b1; pattern = 8'hFF; len = LEN_W'(8); reps = REP_W'(1);
    @(negedge clk);
    start = 1'b0;
    nv = 0; cyc = 0;
    while (nv < 4 && cyc < 20) begin
      if (ser_valid) nv++;
      if (nv < 4) @(negedge clk);
      cyc++;
    end
    check("midreset bits before reset", nv, 4);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midreset");
    rst = 1'b0;
    nv = 0; nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (ser_valid) nv++;
      if (done) nd++;
    end
    check("midreset no done", nd, 0);
    check("midreset no resume", nv, 0);

    // start held high: a new transfer every len*reps+2 cycles.
    @(negedge clk);
    start = 1'b1; pattern = 8'h05; len = LEN_W'(3); reps = REP_W'(1);
    r0 = -100; r1 = -100; prev_v = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ser_valid && !prev_v) begin
        if (r0 < 0) r0 = c;
        else if (r1 < 0) r1 = c;
      end
      prev_v = ser_valid;
    end
    start = 1'b0;
    check("held start period", r1 - r0, 5);
    repeat (10) @(negedge clk);
    check_quiet("final idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the generating end of the FSMs serial sequence-detector interface. On a start request it latches a parallel pattern and shifts it out one bit per clock, MSB-first, over a programmable length. It repeats the frame a programmable number of times, then reports completion. It sits upstream of the sequence detectors, as stimulus source and link driver for single-bit serial pattern streams.

## Interface
Parameters:
- `WIDTH`, default 8: maximum pattern length in bits (≥2).
- `REP_W`, default 4: width of the repeat-count input.
- `LEN_W`, derived as $clog2(WIDTH)+1: width of the length input. Not user-set.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send; latched when start is accepted.
- `len`  in  LEN_W  bits per frame; latched when start is accepted.
- `reps`  in  REP_W  frames to send; latched when start is accepted.
- `ser_out`  out  1  serial data bit, registered.
- `ser_valid`  out  1  ser_out carries a pattern bit this cycle.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, GAP (only with the macro), DONE.
- IDLE, start=1: latch pattern, effective len and effective reps, then go to SHIFT. start=0: stay in IDLE.
- Effective len: len=0 or len>WIDTH means WIDTH.
- Effective reps: reps=0 means 1.
- SHIFT drives pattern[len-1] first, down to pattern[0], one bit per cycle.
- After bit 0 of a frame:
  - If frames remain, reload from the latched pattern and go to SHIFT (or to GAP with the macro).
  - Otherwise go to DONE.
- GAP lasts one cycle, then SHIFT.
- DONE lasts one cycle, then IDLE.
- In IDLE, GAP and DONE: ser_out=0 and ser_valid=0.
- start outside IDLE is ignored. No queuing.
- Input changes after start is accepted have no effect on the transfer in progress.
- rst=1 at any point, including mid-frame: next edge gives state IDLE and ser_out=ser_valid=busy=done=0, and clears the internal counters. The partial frame is abandoned and done is not asserted.
- Bit counter counts 0..len-1. Frame counter counts 0..reps-1. Neither may overflow at len=WIDTH or at reps=2^REP_W−1.

## Timing
- Reset values: all outputs 0, state IDLE.
- Latency: start sampled high at edge k → first bit on ser_out with ser_valid=1 after edge k.
- busy is high from after edge k through the last bit cycle.
- Bit cycles per transfer: len·reps without the macro; len·reps + (reps−1) with it.
- done=1 for exactly one cycle, directly after the last bit cycle. busy=0 in that cycle.
- Earliest restart: start sampled in the cycle after done.
- start held high continuously re-triggers a new transfer every len·reps+2 cycles (no macro).

## Configuration
- Macro: `SEQ_PATTERN_TX_GAP_EN`.
- Defined: GAP state is compiled in. Exactly one idle cycle (ser_valid=0, ser_out=0, busy=1) is inserted between consecutive frames. No gap after the final frame.
- Undefined: GAP state is absent and frames are sent back-to-back.

## Structure
- `seq_pattern_tx_pkg` holds:
  - state enum (IDLE/SHIFT/GAP/DONE);
  - a function computing LEN_W from WIDTH;
  - the effective-length and effective-reps clamp functions.
- One sub-module, `seq_pattern_tx_shreg`: a WIDTH-bit load/shift-left register whose MSB tap is selected by len. The FSM and counters stay in the top module.

## Test plan
- Reset: rst held 3 cycles → all outputs 0. start=1 during reset → no transfer.
- Basic frame: pattern=8'b0000_0001, len=3, reps=1 → ser_out 0,0,1 with ser_valid high for 3 cycles, then done for 1 cycle.
- Repeat:
  - pattern=8'hA5, len=0 (full width 8), reps=2, no macro → 16 bits 10100101 10100101, busy 16 cycles.
  - Same stimulus with the macro → 17 cycles, ser_valid low only at cycle 9.
- Mid-operation events:
  - start pulses and pattern changes during SHIFT → ignored; original bits sent.
  - rst at bit 4 of 8 → outputs 0 next cycle, no done.
- Bounds:
  - len=9 with WIDTH=8 → sends 8 bits.
  - reps=0 → one frame.
  - reps=15 → 15 frames, no counter wrap.
